// File: rtl/legv8_pkg.sv
// Shared LEGv8 pipeline definitions: datapath width, zero register number,
// the ID/EX pipeline register layout and a load-hazard match helper.
package legv8_pkg;

    localparam int N = 64;
    localparam logic [4:0] XZR = 5'd31;

    typedef struct packed {
        logic         valid;
        logic         reg_write;
        logic         is_load;
        logic [4:0]   rd;
        logic [N-1:0] op1;
        logic [N-1:0] op2;
        logic [N-1:0] imm;
    } id_ex_t;

    // True when an in-flight load will write the register a source reads.
    function automatic logic load_match(
        input logic [4:0] src,
        input logic [4:0] rd,
        input logic       is_load,
        input logic       reg_write
    );
        return (src != XZR) && is_load && reg_write && (rd == src);
    endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Single-operand forwarding mux: zero register, then EX/MEM, then MEM/WB,
// then the regfile read data.
module fwd_mux
    import legv8_pkg::*;
#(
    parameter int W = N
) (
    input  logic [4:0]   src,
    input  logic         src_used,
    input  logic [W-1:0] rf_data,
    input  logic         exmem_reg_write,
    input  logic         exmem_is_load,
    input  logic [4:0]   exmem_rd,
    input  logic [W-1:0] exmem_result,
    input  logic         memwb_reg_write,
    input  logic [4:0]   memwb_rd,
    input  logic [W-1:0] memwb_result,
    output logic [W-1:0] operand
);

    // Load data is not ready in EX/MEM, so only ALU results forward from there.
    always_comb begin
        operand = rf_data;
        if (!src_used || src == XZR) begin
            operand = '0;
        end else if (exmem_reg_write && exmem_rd == src && !exmem_is_load) begin
            operand = exmem_result;
        end else if (memwb_reg_write && memwb_rd == src) begin
            operand = memwb_result;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// LEGv8 decode-to-execute stage: operand forwarding, load-use hazard
// detection, the ID/EX pipeline register and a saturating stall counter.
module id_ex_stage
    import legv8_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         id_valid,
    input  logic [4:0]   id_rn,
    input  logic [4:0]   id_rm,
    input  logic [4:0]   id_rd,
    input  logic         id_uses_rm,
    input  logic         id_reg_write,
    input  logic         id_is_load,
    input  logic [N-1:0] id_imm,
    output logic [4:0]   r1_addres,
    output logic [4:0]   r2_addres,
    input  logic [N-1:0] r1_output,
    input  logic [N-1:0] r2_output,
    input  logic         exmem_reg_write,
    input  logic         exmem_is_load,
    input  logic [4:0]   exmem_rd,
    input  logic [N-1:0] exmem_result,
    input  logic         memwb_reg_write,
    input  logic [4:0]   memwb_rd,
    input  logic [N-1:0] memwb_result,
    input  logic         flush,
    input  logic         ex_busy,
    output logic         id_stall,
    output logic         ex_valid,
    output logic         ex_reg_write,
    output logic         ex_is_load,
    output logic [4:0]   ex_rd,
    output logic [N-1:0] ex_op1,
    output logic [N-1:0] ex_op2,
    output logic [N-1:0] ex_imm,
    output logic [31:0]  stall_count
);

    id_ex_t       ex_q;
    logic [N-1:0] op1_fwd;
    logic [N-1:0] op2_fwd;
    logic         rn_hit;
    logic         rm_hit;
    logic         hz;

    assign r1_addres = id_rn;
    assign r2_addres = id_rm;

    fwd_mux #(.W(N)) u_fwd_rn (
        .src             (id_rn),
        .src_used        (1'b1),
        .rf_data         (r1_output),
        .exmem_reg_write (exmem_reg_write),
        .exmem_is_load   (exmem_is_load),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_result    (memwb_result),
        .operand         (op1_fwd)
    );

    fwd_mux #(.W(N)) u_fwd_rm (
        .src             (id_rm),
        .src_used        (id_uses_rm),
        .rf_data         (r2_output),
        .exmem_reg_write (exmem_reg_write),
        .exmem_is_load   (exmem_is_load),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_result    (memwb_result),
        .operand         (op2_fwd)
    );

    // A load in EX or EX/MEM cannot forward yet, so a dependent must wait.
    always_comb begin
        rn_hit = load_match(id_rn, ex_q.rd, ex_q.valid && ex_q.is_load, ex_q.reg_write)
              || load_match(id_rn, exmem_rd, exmem_is_load, exmem_reg_write);
        rm_hit = id_uses_rm
              && (load_match(id_rm, ex_q.rd, ex_q.valid && ex_q.is_load, ex_q.reg_write)
               || load_match(id_rm, exmem_rd, exmem_is_load, exmem_reg_write));
        hz     = id_valid && (rn_hit || rm_hit);
    end

    assign id_stall = hz || ex_busy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_q <= '0;
        end else if (flush) begin
            ex_q.valid <= 1'b0;
        end else if (!ex_busy) begin
            if (hz) begin
                ex_q.valid     <= 1'b0;
                ex_q.reg_write <= 1'b0;
                ex_q.is_load   <= 1'b0;
            end else begin
                ex_q <= '{valid:     id_valid,
                          reg_write: id_reg_write,
                          is_load:   id_is_load,
                          rd:        id_rd,
                          op1:       op1_fwd,
                          op2:       op2_fwd,
                          imm:       id_imm};
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_count <= '0;
        end else if (id_stall && stall_count != 32'hFFFF_FFFF) begin
            stall_count <= stall_count + 32'd1;
        end
    end

    assign ex_valid     = ex_q.valid;
    assign ex_reg_write = ex_q.reg_write;
    assign ex_is_load   = ex_q.is_load;
    assign ex_rd        = ex_q.rd;
    assign ex_op1       = ex_q.op1;
    assign ex_op2       = ex_q.op2;
    assign ex_imm       = ex_q.imm;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_id_ex_stage;
    import legv8_pkg::*;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         id_valid, id_uses_rm, id_reg_write, id_is_load;
    logic [4:0]   id_rn, id_rm, id_rd;
    logic [N-1:0] id_imm;
    logic [4:0]   r1_addres, r2_addres;
    logic [N-1:0] r1_output, r2_output;
    logic         exmem_reg_write, exmem_is_load;
    logic [4:0]   exmem_rd;
    logic [N-1:0] exmem_result;
    logic         memwb_reg_write;
    logic [4:0]   memwb_rd;
    logic [N-1:0] memwb_result;
    logic         flush, ex_busy, id_stall;
    logic         ex_valid, ex_reg_write, ex_is_load;
    logic [4:0]   ex_rd;
    logic [N-1:0] ex_op1, ex_op2, ex_imm;
    logic [31:0]  stall_count;

    logic [N-1:0] rf_mem [32];
    int           n_checks = 0;
    int           n_errors = 0;
    logic         chk_en = 1'b0;

    // Behavioural model of what ID/EX must hold, and its next value.
    logic         m_valid = 0, m_rw = 0, m_ld = 0;
    logic [4:0]   m_rd = 0;
    logic [N-1:0] m_op1 = 0, m_op2 = 0, m_imm = 0;
    logic [31:0]  m_cnt = 0;
    logic         n_valid = 0, n_rw = 0, n_ld = 0;
    logic [4:0]   n_rd = 0;
    logic [N-1:0] n_op1 = 0, n_op2 = 0, n_imm = 0;
    logic [31:0]  n_cnt = 0;

    always #5 clk = ~clk;

    assign r1_output = rf_mem[r1_addres];
    assign r2_output = rf_mem[r2_addres];

    id_ex_stage dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .id_valid        (id_valid),
        .id_rn           (id_rn),
        .id_rm           (id_rm),
        .id_rd           (id_rd),
        .id_uses_rm      (id_uses_rm),
        .id_reg_write    (id_reg_write),
        .id_is_load      (id_is_load),
        .id_imm          (id_imm),
        .r1_addres       (r1_addres),
        .r2_addres       (r2_addres),
        .r1_output       (r1_output),
        .r2_output       (r2_output),
        .exmem_reg_write (exmem_reg_write),
        .exmem_is_load   (exmem_is_load),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_result    (memwb_result),
        .flush           (flush),
        .ex_busy         (ex_busy),
        .id_stall        (id_stall),
        .ex_valid        (ex_valid),
        .ex_reg_write    (ex_reg_write),
        .ex_is_load      (ex_is_load),
        .ex_rd           (ex_rd),
        .ex_op1          (ex_op1),
        .ex_op2          (ex_op2),
        .ex_imm          (ex_imm),
        .stall_count     (stall_count)
    );

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] exp_operand(input logic [4:0] s, input logic used);
        if (!used || s == 5'd31) return '0;
        if (exmem_reg_write && exmem_rd == s && !exmem_is_load) return exmem_result;
        if (memwb_reg_write && memwb_rd == s) return memwb_result;
        return rf_mem[s];
    endfunction

    // Compare against the model mid-cycle, then work out the model's next state.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [31:0] pend;
            logic        e_hz, e_stall;
            check_output("ex_valid", 64'(ex_valid), 64'(m_valid));
            check_output("ex_reg_write", 64'(ex_reg_write), 64'(m_rw));
            check_output("ex_is_load", 64'(ex_is_load), 64'(m_ld));
            check_output("ex_rd", 64'(ex_rd), 64'(m_rd));
            check_output("ex_op1", ex_op1, m_op1);
            check_output("ex_op2", ex_op2, m_op2);
            check_output("ex_imm", ex_imm, m_imm);
            check_output("stall_count", 64'(stall_count), 64'(m_cnt));
            pend = '0;
            if (m_valid && m_ld && m_rw) pend[m_rd] = 1'b1;
            if (exmem_is_load && exmem_reg_write) pend[exmem_rd] = 1'b1;
            pend[31] = 1'b0;
            e_hz    = id_valid && (pend[id_rn] || (id_uses_rm && pend[id_rm]));
            e_stall = e_hz || ex_busy;
            check_output("id_stall", 64'(id_stall), 64'(e_stall));
            check_output("r1_addres", 64'(r1_addres), 64'(id_rn));
            check_output("r2_addres", 64'(r2_addres), 64'(id_rm));
            n_valid <= m_valid; n_rw <= m_rw; n_ld <= m_ld; n_rd <= m_rd;
            n_op1 <= m_op1; n_op2 <= m_op2; n_imm <= m_imm;
            if (flush) begin
                n_valid <= 1'b0;
            end else if (!ex_busy && e_hz) begin
                n_valid <= 1'b0; n_rw <= 1'b0; n_ld <= 1'b0;
            end else if (!ex_busy) begin
                n_valid <= id_valid; n_rw <= id_reg_write; n_ld <= id_is_load;
                n_rd <= id_rd; n_imm <= id_imm;
                n_op1 <= exp_operand(id_rn, 1'b1);
                n_op2 <= exp_operand(id_rm, id_uses_rm);
            end
            n_cnt <= (e_stall && m_cnt != 32'hFFFF_FFFF) ? m_cnt + 32'd1 : m_cnt;
        end
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_valid <= 0; m_rw <= 0; m_ld <= 0; m_rd <= 0;
            m_op1 <= 0; m_op2 <= 0; m_imm <= 0; m_cnt <= 0;
        end else if (chk_en) begin
            m_valid <= n_valid; m_rw <= n_rw; m_ld <= n_ld; m_rd <= n_rd;
            m_op1 <= n_op1; m_op2 <= n_op2; m_imm <= n_imm; m_cnt <= n_cnt;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_valid = 0; id_uses_rm = 0; id_reg_write = 0; id_is_load = 0;
        id_rn = 0; id_rm = 0; id_rd = 0; id_imm = '0;
        exmem_reg_write = 0; exmem_is_load = 0; exmem_rd = 0; exmem_result = '0;
        memwb_reg_write = 0; memwb_rd = 0; memwb_result = '0;
        flush = 0; ex_busy = 0;
    endtask

    task automatic do_reset();
        step();
        reset_n = 0;
        clear_inputs();
        #2 reset_n = 1;
    endtask

    task automatic apply_stimulus(input logic v, input logic [4:0] rn, input logic [4:0] rm,
                                  input logic [4:0] rd, input logic urm, input logic rw,
                                  input logic ld, input logic [N-1:0] imm);
        id_valid = v; id_rn = rn; id_rm = rm; id_rd = rd;
        id_uses_rm = urm; id_reg_write = rw; id_is_load = ld; id_imm = imm;
    endtask

    function automatic logic [4:0] rand_reg();
        logic [4:0] r;
        r = 5'($urandom_range(0, 7));
        return (r == 5'd7) ? 5'd31 : r;
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) rf_mem[i] = {$urandom, $urandom};
        rf_mem[1] = 64'd1;
        rf_mem[2] = 64'd2;
        clear_inputs();
        reset_n = 1;
        #1 reset_n = 0;
        #2;
        check_output("reset_ex_valid", 64'(ex_valid), 64'd0);
        check_output("reset_stall_count", 64'(stall_count), 64'd0);
        step();
        reset_n = 1;
        chk_en  = 1;

        // No hazard: plain regfile operands.
        apply_stimulus(1, 5'd1, 5'd2, 5'd3, 1, 1, 0, 64'd7);
        step();
        check_output("nohz_op1", ex_op1, 64'd1);
        check_output("nohz_op2", ex_op2, 64'd2);
        check_output("nohz_valid", 64'(ex_valid), 64'd1);

        // Forwarding priority: EX/MEM over MEM/WB, then MEM/WB alone.
        id_rn = 5'd3;
        exmem_reg_write = 1; exmem_rd = 5'd3; exmem_result = 64'hAA;
        memwb_reg_write = 1; memwb_rd = 5'd3; memwb_result = 64'hBB;
        step();
        check_output("fwd_exmem", ex_op1, 64'hAA);
        exmem_reg_write = 0;
        step();
        check_output("fwd_memwb", ex_op1, 64'hBB);

        // The zero register is never forwarded.
        memwb_reg_write = 0;
        id_rn = 5'd31; exmem_reg_write = 1; exmem_rd = 5'd31; exmem_result = 64'd5;
        step();
        check_output("xzr_op1", ex_op1, 64'd0);

        // Load-use: LDUR X4 then ADD X5,X4,X4.
        do_reset();
        apply_stimulus(1, 5'd1, 5'd2, 5'd4, 0, 1, 1, 64'd0);
        step();
        check_output("ld_in_ex", 64'(ex_is_load), 64'd1);
        apply_stimulus(1, 5'd4, 5'd4, 5'd5, 1, 1, 0, 64'd0);
        #1 check_output("lu_stall1", 64'(id_stall), 64'd1);
        step();
        check_output("lu_bubble1", 64'(ex_valid), 64'd0);
        exmem_rd = 5'd4; exmem_is_load = 1; exmem_reg_write = 1;
        #1 check_output("lu_stall2", 64'(id_stall), 64'd1);
        step();
        check_output("lu_bubble2", 64'(ex_valid), 64'd0);
        exmem_rd = 0; exmem_is_load = 0; exmem_reg_write = 0;
        memwb_reg_write = 1; memwb_rd = 5'd4; memwb_result = 64'h1234;
        #1 check_output("lu_nostall", 64'(id_stall), 64'd0);
        step();
        check_output("lu_valid", 64'(ex_valid), 64'd1);
        check_output("lu_op1", ex_op1, 64'h1234);
        check_output("lu_op2", ex_op2, 64'h1234);
        check_output("lu_rd", 64'(ex_rd), 64'd5);
        check_output("lu_count", 64'(stall_count), 64'd2);

        // Busy holds ID/EX and counts stalls; flush beats busy.
        do_reset();
        apply_stimulus(1, 5'd1, 5'd2, 5'd6, 1, 1, 0, 64'h55);
        step();
        apply_stimulus(1, 5'd2, 5'd1, 5'd7, 1, 1, 0, 64'h66);
        ex_busy = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_output("busy_hold_op1", ex_op1, 64'd1);
            check_output("busy_hold_imm", ex_imm, 64'h55);
        end
        check_output("busy_count", 64'(stall_count), 64'd3);
        flush = 1;
        step();
        check_output("flush_busy_valid", 64'(ex_valid), 64'd0);
        check_output("flush_busy_count", 64'(stall_count), 64'd4);

        // Asynchronous reset in the middle of a load-use stall.
        do_reset();
        apply_stimulus(1, 5'd1, 5'd2, 5'd4, 0, 1, 1, 64'h9);
        step();
        apply_stimulus(1, 5'd4, 5'd0, 5'd5, 0, 1, 0, 64'h0);
        step();
        reset_n = 0;
        #1;
        check_output("arst_valid", 64'(ex_valid), 64'd0);
        check_output("arst_is_load", 64'(ex_is_load), 64'd0);
        check_output("arst_rd", 64'(ex_rd), 64'd0);
        check_output("arst_imm", ex_imm, 64'd0);
        check_output("arst_count", 64'(stall_count), 64'd0);
        check_output("arst_stall", 64'(id_stall), 64'd0);
        #1 reset_n = 1;

        // Randomized traffic checked by the model every cycle.
        clear_inputs();
        for (int c = 0; c < 400; c++) begin
            apply_stimulus(1'($urandom_range(0, 3) != 0), rand_reg(), rand_reg(), rand_reg(),
                           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 2) == 0), {$urandom, $urandom});
            exmem_reg_write = 1'($urandom_range(0, 1));
            exmem_is_load   = 1'($urandom_range(0, 2) == 0);
            exmem_rd        = rand_reg();
            exmem_result    = {$urandom, $urandom};
            memwb_reg_write = 1'($urandom_range(0, 1));
            memwb_rd        = rand_reg();
            memwb_result    = {$urandom, $urandom};
            flush           = 1'($urandom_range(0, 9) == 0);
            ex_busy         = 1'($urandom_range(0, 6) == 0);
            step();
        end

        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
